// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body register block.
// Holds heading and state encodings, default geometry and helpers.
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_UP    = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int DEF_MAX_LEN  = 8;
   localparam int DEF_INIT_LEN = 4;
   localparam int DEF_XDIM     = 10;
   localparam int DEF_YDIM     = 10;
   localparam int DEF_XSCREEN  = 160;
   localparam int DEF_YSCREEN  = 120;
   localparam int DEF_X_INIT   = 80;
   localparam int DEF_Y_INIT   = 60;

   // Opposite headings differ only in bit 0.
   function automatic dir_e dir_opposite(dir_e d);
      return dir_e'(d ^ 2'b01);
   endfunction

   // Reset x of segment i: body trails to the left of the head.
   function automatic logic [7:0] seg_init_x(int x0, int i, int xd);
      return 8'(x0 - i * xd);
   endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator with wall detection.
// Ports: head_x_i/head_y_i/dir_i in; next_x_o/next_y_o/wall_o out.
module snake_next_head
   import snake_pkg::*;
#(
   parameter int XDIM    = DEF_XDIM,
   parameter int YDIM    = DEF_YDIM,
   parameter int XSCREEN = DEF_XSCREEN,
   parameter int YSCREEN = DEF_YSCREEN
) (
   input  logic [7:0] head_x_i,
   input  logic [6:0] head_y_i,
   input  dir_e       dir_i,
   output logic [7:0] next_x_o,
   output logic [6:0] next_y_o,
   output logic       wall_o
);

   localparam logic signed [8:0] XSTEP = 9'(XDIM);
   localparam logic signed [8:0] YSTEP = 9'(YDIM);
   localparam logic signed [8:0] XMAX  = 9'(XSCREEN - XDIM);
   localparam logic signed [8:0] YMAX  = 9'(YSCREEN - YDIM);

   logic signed [8:0] cur_x;
   logic signed [8:0] cur_y;
   logic signed [8:0] nx;
   logic signed [8:0] ny;

   // 9-bit signed so stepping off the top/left goes negative.
   assign cur_x = $signed({1'b0, head_x_i});
   assign cur_y = $signed({2'b00, head_y_i});

   always_comb begin
      nx = cur_x;
      ny = cur_y;
      unique case (dir_i)
         DIR_RIGHT: nx = cur_x + XSTEP;
         DIR_LEFT:  nx = cur_x - XSTEP;
         DIR_DOWN:  ny = cur_y + YSTEP;
         DIR_UP:    ny = cur_y - YSTEP;
      endcase
   end

   assign wall_o   = nx[8] || (nx > XMAX) || ny[8] || (ny > YMAX);
   assign next_x_o = nx[7:0];
   assign next_y_o = ny[6:0];

endmodule

// File: rtl/snake_body_regs.sv
// Snake segment registers, heading, step sequencer and collision scan.
// Ports: Clock/Resetn, init, step, dir_in/dir_valid, grow, rd_idx in;
//        rd_x/rd_y/rd_valid, length, busy, done, dead, hit_wall/hit_self out.
module snake_body_regs
   import snake_pkg::*;
#(
   parameter int MAX_LEN  = DEF_MAX_LEN,
   parameter int INIT_LEN = DEF_INIT_LEN,
   parameter int XDIM     = DEF_XDIM,
   parameter int YDIM     = DEF_YDIM,
   parameter int XSCREEN  = DEF_XSCREEN,
   parameter int YSCREEN  = DEF_YSCREEN,
   parameter int X_INIT   = DEF_X_INIT,
   parameter int Y_INIT   = DEF_Y_INIT
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       init,
   input  logic       step,
   input  logic [1:0] dir_in,
   input  logic       dir_valid,
   input  logic       grow,
   input  logic [2:0] rd_idx,
   output logic [7:0] rd_x,
   output logic [6:0] rd_y,
   output logic       rd_valid,
   output logic [3:0] length,
   output logic       busy,
   output logic       done,
   output logic       dead,
   output logic       hit_wall,
   output logic       hit_self
);

   logic [7:0] seg_x_q [MAX_LEN];
   logic [7:0] seg_x_d [MAX_LEN];
   logic [6:0] seg_y_q [MAX_LEN];
   logic [6:0] seg_y_d [MAX_LEN];
   logic [3:0] len_q, len_d;
   logic [2:0] scan_q, scan_d;
   dir_e       head_q, head_d;
   state_e     state_q, state_d;
   logic       dead_q, dead_d;
   logic       hw_q, hw_d;
   logic       hs_q, hs_d;

   logic [7:0] nx;
   logic [6:0] ny;
   logic       wall;
   logic       match;
   logic       last;

   snake_next_head #(
      .XDIM    (XDIM),
      .YDIM    (YDIM),
      .XSCREEN (XSCREEN),
      .YSCREEN (YSCREEN)
   ) u_next (
      .head_x_i (seg_x_q[0]),
      .head_y_i (seg_y_q[0]),
      .dir_i    (head_q),
      .next_x_o (nx),
      .next_y_o (ny),
      .wall_o   (wall)
   );

   assign match = (seg_x_q[scan_q] == seg_x_q[0]) &&
                  (seg_y_q[scan_q] == seg_y_q[0]);
   assign last  = ({1'b0, scan_q} == (len_q - 4'd1));

   always_comb begin
      seg_x_d = seg_x_q;
      seg_y_d = seg_y_q;
      len_d   = len_q;
      scan_d  = scan_q;
      head_d  = head_q;
      state_d = state_q;
      dead_d  = dead_q;
      hw_d    = hw_q;
      hs_d    = hs_q;

      // Reversal requests are dropped so the head can't fold back.
      if (dir_valid && (dir_e'(dir_in) != dir_opposite(head_q)))
         head_d = dir_e'(dir_in);

      if (init) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_init_x(X_INIT, i, XDIM);
            seg_y_d[i] = 7'(Y_INIT);
         end
         len_d   = 4'(INIT_LEN);
         scan_d  = '0;
         head_d  = DIR_RIGHT;
         state_d = ST_IDLE;
         dead_d  = 1'b0;
         hw_d    = 1'b0;
         hs_d    = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (step && !dead_q) begin
                  if (wall) begin
                     dead_d  = 1'b1;
                     hw_d    = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x_d[i] = seg_x_q[i-1];
                        seg_y_d[i] = seg_y_q[i-1];
                     end
                     seg_x_d[0] = nx;
                     seg_y_d[0] = ny;
                     // Shift already kept the old tail alive.
                     if (grow && (len_q < 4'(MAX_LEN)))
                        len_d = len_q + 4'd1;
                     scan_d  = 3'd1;
                     state_d = ST_SCAN;
                  end
               end
            end
            ST_SCAN: begin
               if (match) begin
                  dead_d  = 1'b1;
                  hs_d    = 1'b1;
                  state_d = ST_DONE;
               end else if (last) begin
                  state_d = ST_DONE;
               end else begin
                  scan_d = scan_q + 3'd1;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_q[i] <= seg_init_x(X_INIT, i, XDIM);
            seg_y_q[i] <= 7'(Y_INIT);
         end
         len_q   <= 4'(INIT_LEN);
         scan_q  <= '0;
         head_q  <= DIR_RIGHT;
         state_q <= ST_IDLE;
         dead_q  <= 1'b0;
         hw_q    <= 1'b0;
         hs_q    <= 1'b0;
      end else begin
         seg_x_q <= seg_x_d;
         seg_y_q <= seg_y_d;
         len_q   <= len_d;
         scan_q  <= scan_d;
         head_q  <= head_d;
         state_q <= state_d;
         dead_q  <= dead_d;
         hw_q    <= hw_d;
         hs_q    <= hs_d;
      end
   end

   assign rd_x     = seg_x_q[rd_idx];
   assign rd_y     = seg_y_q[rd_idx];
   assign rd_valid = ({1'b0, rd_idx} < len_q);
   assign length   = len_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign dead     = dead_q;
   assign hit_wall = hw_q;
   assign hit_self = hs_q;

endmodule

// File: tb/tb_snake_body_regs.sv
// Testbench for snake_body_regs: directed scenarios plus random play
// checked against a coordinate-list model of the snake.
module tb_snake_body_regs;

   logic       Clock = 1'b0;
   logic       Resetn = 1'b1;
   logic       init = 1'b0;
   logic       step = 1'b0;
   logic [1:0] dir_in = 2'd0;
   logic       dir_valid = 1'b0;
   logic       grow = 1'b0;
   logic [2:0] rd_idx = 3'd0;
   logic [7:0] rd_x;
   logic [6:0] rd_y;
   logic       rd_valid;
   logic [3:0] length;
   logic       busy;
   logic       done;
   logic       dead;
   logic       hit_wall;
   logic       hit_self;

   int checks = 0;
   int errors = 0;

   int mx [8];
   int my [8];
   int mlen;
   int mhead;
   bit mdead, mhw, mhs;

   snake_body_regs dut (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .init      (init),
      .step      (step),
      .dir_in    (dir_in),
      .dir_valid (dir_valid),
      .grow      (grow),
      .rd_idx    (rd_idx),
      .rd_x      (rd_x),
      .rd_y      (rd_y),
      .rd_valid  (rd_valid),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .dead      (dead),
      .hit_wall  (hit_wall),
      .hit_self  (hit_self)
   );

   always #5 Clock = ~Clock;

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) begin
         mx[i] = 80 - 10 * i;
         my[i] = 60;
      end
      mlen = 4; mhead = 0;
      mdead = 0; mhw = 0; mhs = 0;
   endfunction

   function automatic void model_dir(int d);
      if (d != (mhead ^ 1)) mhead = d;
   endfunction

   // Returns clock edges from step until done is seen, -1 if no done.
   function automatic int model_step(bit g);
      int nx, ny;
      if (mdead) return -1;
      nx = mx[0]; ny = my[0];
      case (mhead)
         0: nx += 10;
         1: nx -= 10;
         2: ny += 10;
         default: ny -= 10;
      endcase
      if (nx < 0 || nx > 150 || ny < 0 || ny > 110) begin
         mdead = 1; mhw = 1;
         return 1;
      end
      for (int i = 7; i > 0; i--) begin
         mx[i] = mx[i-1]; my[i] = my[i-1];
      end
      mx[0] = nx; my[0] = ny;
      if (g && mlen < 8) mlen++;
      for (int k = 1; k < mlen; k++)
         if (mx[k] == nx && my[k] == ny) begin
            mdead = 1; mhs = 1;
            return k + 1;
         end
      return mlen;
   endfunction

   task automatic do_init();
      init = 1'b1;
      @(posedge Clock); #1;
      init = 1'b0;
      model_reset();
   endtask

   task automatic set_dir(int d);
      dir_in = 2'(d); dir_valid = 1'b1;
      @(posedge Clock); #1;
      dir_valid = 1'b0;
      model_dir(d);
   endtask

   task automatic run_step(bit g, int maxc, output int edges, output bit seen);
      step = 1'b1; grow = g;
      edges = 0; seen = 0;
      repeat (maxc) begin
         @(posedge Clock); #1;
         step = 1'b0; grow = 1'b0;
         edges++;
         if (done) begin seen = 1; break; end
      end
      step = 1'b0; grow = 1'b0;
      if (seen) begin @(posedge Clock); #1; end
   endtask

   task automatic test_reset();
      #1 Resetn = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      model_reset();
      checks++;
      if ({length, busy, done, dead, hit_wall, hit_self} !== {4'd4, 5'b0}) begin
         errors++;
         $display("FAIL reset_flags: got len=%0d b=%b d=%b dead=%b hw=%b hs=%b",
                  length, busy, done, dead, hit_wall, hit_self);
      end
      for (int i = 0; i < 8; i++) begin
         rd_idx = 3'(i); #1;
         checks++;
         if (rd_x !== 8'(mx[i]) || rd_y !== 7'(my[i]) || rd_valid !== (i < mlen)) begin
            errors++;
            $display("FAIL reset_seg%0d: got (%0d,%0d,v%b) want (%0d,%0d)",
                     i, rd_x, rd_y, rd_valid, mx[i], my[i]);
         end
      end
      @(posedge Clock); #1 Resetn = 1'b1;
      @(posedge Clock); #1;
   endtask

   task automatic test_step_basic();
      int exp, e; bit s;
      exp = model_step(0);
      run_step(0, 20, e, s);
      checks++;
      if (!s || e != exp || exp != 4) begin
         errors++;
         $display("FAIL basic_latency: got %0d seen=%b want 4", e, s);
      end
      rd_idx = 3'd0; #1;
      checks++;
      if (rd_x !== 8'd90 || rd_y !== 7'd60) begin
         errors++;
         $display("FAIL basic_head: got (%0d,%0d) want (90,60)", rd_x, rd_y);
      end
      rd_idx = 3'd1; #1;
      checks++;
      if (rd_x !== 8'd80 || rd_y !== 7'd60) begin
         errors++;
         $display("FAIL basic_seg1: got (%0d,%0d) want (80,60)", rd_x, rd_y);
      end
      rd_idx = 3'd3; #1;
      checks++;
      if (rd_x !== 8'd60 || rd_y !== 7'd60 || rd_valid !== 1'b1) begin
         errors++;
         $display("FAIL basic_seg3: got (%0d,%0d) want (60,60)", rd_x, rd_y);
      end
      rd_idx = 3'd4; #1;
      checks++;
      if (rd_valid !== 1'b0 || length !== 4'd4 || dead !== 1'b0) begin
         errors++;
         $display("FAIL basic_len: got v4=%b len=%0d dead=%b want 0,4,0",
                  rd_valid, length, dead);
      end
   endtask

   task automatic test_reversal();
      int exp, e; bit s;
      do_init();
      set_dir(1);
      exp = model_step(0);
      run_step(0, 20, e, s);
      rd_idx = 3'd0; #1;
      checks++;
      if (!s || e != exp || rd_x !== 8'd90 || rd_y !== 7'd60) begin
         errors++;
         $display("FAIL reversal_ignored: got (%0d,%0d) e=%0d want (90,60) e=%0d",
                  rd_x, rd_y, e, exp);
      end
      set_dir(3);
      exp = model_step(0);
      run_step(0, 20, e, s);
      rd_idx = 3'd0; #1;
      checks++;
      if (!s || e != exp || rd_x !== 8'd90 || rd_y !== 7'd50) begin
         errors++;
         $display("FAIL turn_up: got (%0d,%0d) e=%0d want (90,50) e=%0d",
                  rd_x, rd_y, e, exp);
      end
   endtask

   task automatic test_grow();
      int exp, e; bit s;
      int want_len [5] = '{5, 6, 7, 8, 8};
      do_init();
      set_dir(2);
      for (int n = 0; n < 5; n++) begin
         exp = model_step(1);
         run_step(1, 20, e, s);
         checks++;
         if (!s || e != exp || length !== 4'(want_len[n]) || mlen != want_len[n]) begin
            errors++;
            $display("FAIL grow_%0d: got len=%0d e=%0d want len=%0d e=%0d",
                     n, length, e, want_len[n], exp);
         end
      end
      for (int i = 0; i < 8; i++) begin
         rd_idx = 3'(i); #1;
         checks++;
         if (rd_x !== 8'(mx[i]) || rd_y !== 7'(my[i]) || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL grow_seg%0d: got (%0d,%0d,v%b) want (%0d,%0d,v1)",
                     i, rd_x, rd_y, rd_valid, mx[i], my[i]);
         end
      end
   endtask

   task automatic test_wall();
      int exp, e; bit s;
      do_init();
      set_dir(3);
      for (int n = 0; n < 6; n++) begin
         exp = model_step(0);
         run_step(0, 20, e, s);
         checks++;
         if (!s || e != exp || dead !== 1'b0) begin
            errors++;
            $display("FAIL wall_approach_%0d: got e=%0d dead=%b want e=%0d", n, e, dead, exp);
         end
      end
      exp = model_step(0);
      run_step(0, 20, e, s);
      rd_idx = 3'd0; #1;
      checks++;
      if (!s || e != 1 || exp != 1 || dead !== 1'b1 || hit_wall !== 1'b1 ||
          hit_self !== 1'b0 || rd_x !== 8'd80 || rd_y !== 7'd0) begin
         errors++;
         $display("FAIL wall_hit: got e=%0d dead=%b hw=%b hs=%b head=(%0d,%0d) want e=1 (80,0)",
                  e, dead, hit_wall, hit_self, rd_x, rd_y);
      end
      exp = model_step(0);
      run_step(0, 8, e, s);
      checks++;
      if (s || exp != -1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL dead_step: got done=%b busy=%b want no done", s, busy);
      end
   endtask

   task automatic test_self_hit();
      int exp, e; bit s;
      int dirs [4] = '{0, 2, 1, 3};
      do_init();
      exp = model_step(1);
      run_step(1, 20, e, s);
      for (int n = 0; n < 4; n++) begin
         set_dir(dirs[n]);
         exp = model_step(0);
         run_step(0, 20, e, s);
      end
      checks++;
      if (!s || e != exp || exp != 5 || dead !== 1'b1 || hit_self !== 1'b1 ||
          hit_wall !== 1'b0 || length !== 4'd5) begin
         errors++;
         $display("FAIL self_hit: got e=%0d dead=%b hs=%b hw=%b len=%0d want e=5 1 1 0 5",
                  e, dead, hit_self, hit_wall, length);
      end
   endtask

   task automatic test_init_abort();
      int dones;
      do_init();
      step = 1'b1;
      @(posedge Clock); #1;
      step = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_in_scan: got busy=%b want 1", busy);
      end
      init = 1'b1;
      @(posedge Clock); #1;
      init = 1'b0;
      model_reset();
      dones = (done === 1'b1) ? 1 : 0;
      repeat (6) begin
         @(posedge Clock); #1;
         if (done === 1'b1) dones++;
      end
      checks++;
      if (dones != 0 || busy !== 1'b0 || dead !== 1'b0 || length !== 4'd4) begin
         errors++;
         $display("FAIL abort_idle: got dones=%0d busy=%b dead=%b len=%0d want 0 0 0 4",
                  dones, busy, dead, length);
      end
      for (int i = 0; i < 8; i++) begin
         rd_idx = 3'(i); #1;
         checks++;
         if (rd_x !== 8'(mx[i]) || rd_y !== 7'(my[i])) begin
            errors++;
            $display("FAIL abort_seg%0d: got (%0d,%0d) want (%0d,%0d)",
                     i, rd_x, rd_y, mx[i], my[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      do_init();
      set_dir(2);
      step = 1'b1;
      @(posedge Clock); #1;
      step = 1'b0;
      #2 Resetn = 1'b0;
      #1;
      model_reset();
      rd_idx = 3'd0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || length !== 4'd4 || dead !== 1'b0 ||
          rd_x !== 8'd80 || rd_y !== 7'd60) begin
         errors++;
         $display("FAIL async_reset: got busy=%b done=%b len=%0d head=(%0d,%0d)",
                  busy, done, length, rd_x, rd_y);
      end
      @(posedge Clock); #1 Resetn = 1'b1;
      @(posedge Clock); #1;
      set_dir(1);
      checks++;
      begin
         int exp, e; bit s;
         exp = model_step(0);
         run_step(0, 20, e, s);
         rd_idx = 3'd0; #1;
         if (!s || e != exp || rd_x !== 8'd90) begin
            errors++;
            $display("FAIL async_heading: got x=%0d e=%0d want 90 e=%0d", rd_x, e, exp);
         end
      end
   endtask

   task automatic test_random();
      int exp, e; bit s, g;
      do_init();
      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(0, 2) == 0) set_dir(int'($urandom_range(0, 3)));
         g = ($urandom_range(0, 3) == 0);
         exp = model_step(g);
         run_step(g, (exp < 0) ? 8 : exp + 3, e, s);
         checks++;
         if ((exp < 0 && s) || (exp >= 0 && (!s || e != exp)) ||
             length !== 4'(mlen) || dead !== mdead || hit_wall !== mhw ||
             hit_self !== mhs || busy !== 1'b0) begin
            errors++;
            $display("FAIL rand_step%0d: got e=%0d s=%b len=%0d d/w/s=%b%b%b want e=%0d len=%0d d/w/s=%b%b%b",
                     n, e, s, length, dead, hit_wall, hit_self, exp, mlen, mdead, mhw, mhs);
         end
         for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i); #1;
            checks++;
            if (rd_x !== 8'(mx[i]) || rd_y !== 7'(my[i]) || rd_valid !== (i < mlen)) begin
               errors++;
               $display("FAIL rand_seg%0d_%0d: got (%0d,%0d,v%b) want (%0d,%0d)",
                        n, i, rd_x, rd_y, rd_valid, mx[i], my[i]);
            end
         end
         if (mdead || $urandom_range(0, 19) == 0) do_init();
      end
   endtask

   initial begin
      test_reset();
      test_step_basic();
      test_reversal();
      test_grow();
      test_wall();
      test_self_hit();
      test_init_abort();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1);
   end

endmodule

// File: doc/snake_body_regs.md
Name: snake_body_regs

Overview:
- Holds the snake's segment coordinates, length, heading and alive/dead status.
- Sits directly upstream of the VGA draw/erase FSM. On each animation tick (step) it advances the head one cell, shifts the body, optionally grows, then scans for self-collision.
- The draw FSM reads segment coordinates through a combinational indexed read port and starts drawing after done.

Parameters:
- MAX_LEN, 8, maximum segment count (index width 3 bits, length width 4 bits)
- INIT_LEN, 4, segment count after reset/init (2..MAX_LEN)
- XDIM, 10, cell width in pixels; also the x step size
- YDIM, 10, cell height in pixels; also the y step size
- XSCREEN, 160, screen width in pixels
- YSCREEN, 120, screen height in pixels
- X_INIT, 80, head x after reset/init
- Y_INIT, 60, head y after reset/init

Ports:
- Clock  in  1  system clock (CLOCK_50)
- Resetn  in  1  asynchronous active-low reset
- init  in  1  synchronous reload of the reset state
- step  in  1  one-cycle move request (driven by the sync tick)
- dir_in  in  2  requested heading: 0 right, 1 left, 2 down, 3 up
- dir_valid  in  1  qualifies dir_in
- grow  in  1  sampled with step; extends the snake by one segment
- rd_idx  in  3  segment index (0 = head)
- rd_x  out  8  x of segment rd_idx
- rd_y  out  7  y of segment rd_idx
- rd_valid  out  1  rd_idx < length
- length  out  4  current segment count
- busy  out  1  high while not in IDLE
- done  out  1  one-cycle pulse at the end of a step
- dead  out  1  sticky game-over flag
- hit_wall  out  1  sticky; dead was caused by a wall
- hit_self  out  1  sticky; dead was caused by the body

Behaviour:
- Reset and init values:
  - seg[i] = (X_INIT - i*XDIM, Y_INIT) for all i < MAX_LEN
  - length = INIT_LEN; heading = right
  - dead, hit_wall, hit_self, done, busy = 0; state = IDLE
- init:
  - Takes effect in any state and has priority over step.
  - Mid-scan init aborts to IDLE with no done pulse.
- Heading register:
  - Updated in any state when dir_valid = 1, except when dir_in == heading ^ 1 (reversal), which is ignored.
  - Takes effect on the next accepted step.
- States: IDLE, SCAN, DONE.
- IDLE:
  - step is accepted only when dead = 0; otherwise it is ignored and no done is generated.
  - Next head = seg[0] moved one cell (±XDIM in x or ±YDIM in y).
  - Wall condition: next x < 0 or > XSCREEN-XDIM, or next y < 0 or > YSCREEN-YDIM. Compute with 9-bit signed arithmetic; no wrap-around.
  - On a wall at edge e0: segments are unchanged; dead = 1, hit_wall = 1; state -> DONE.
  - Otherwise at e0:
    - seg[i] <= seg[i-1] for i >= 1; seg[0] <= next head.
    - If grow = 1 and length < MAX_LEN, length += 1 (the old tail survives via the shift). If grow = 1 and length = MAX_LEN, grow is ignored.
    - state -> SCAN, scan_idx = 1.
- SCAN:
  - Each cycle compares seg[scan_idx] with seg[0].
  - On a match: dead = 1, hit_self = 1; state -> DONE.
  - Else if scan_idx == length-1: state -> DONE.
  - Else scan_idx += 1.
- DONE: done = 1 for exactly one cycle; state -> IDLE.
- Latency:
  - Clean step: done is high in the cycle after edge e(length-1).
  - Wall: done is high in the cycle after e0.
- busy = (state != IDLE). step while busy is dropped.
- Read port is combinational from the registers. Segments at index >= length hold stale values; rd_valid = 0 for them.
- Resetn asserted mid-operation: all outputs return to their reset values immediately (asynchronous).

Decomposition:
- Package snake_pkg holds:
  - DIR_RIGHT = 0, DIR_LEFT = 1, DIR_DOWN = 2, DIR_UP = 3, and the reversal rule (opposite = dir ^ 1)
  - state encoding for IDLE, SCAN, DONE
  - default screen and cell constants
- One sub-module: snake_next_head. It is combinational and takes head x/y, heading and the parameters, and returns next x/y plus the wall flag.

Test Plan:
- Reset, then step with heading right → after 3 scan cycles done pulses. seg0 = (90,60), seg1 = (80,60), seg3 = (60,60); length = 4; dead = 0.
- dir_in = left (reversal of right), then step → dir_in is ignored and the head moves to (90,60). Then dir_in = up, then step → head moves to (90,50) after that previous step.
- grow = 1 with step, repeated 5 times from reset → length goes 5, 6, 7, 8, 8. rd_idx = 7 returns the old tail and rd_valid = 1.
- Heading up from (80,60), 6 steps → head at (80,0). The 7th step gives done one cycle after the step edge, dead = 1, hit_wall = 1, and head stays at (80,0). A further step gives no done.
- Length 5, headings right, down, left, up in consecutive steps → the head lands on seg[4]. Result: dead = 1, hit_self = 1, done pulses.
- Assert init during SCAN → state goes to IDLE with no done. Segments return to (80,60) … (50,60); dead = 0.
